// File: rtl/f2c_pattern_src.sv
// f2c_pattern_src: test-pattern source for the FPGA-to-CPU DMA stream.
// It emits 64-bit words on a valid/ready stream, in bursts of burstLen_in words
// separated by gap_in idle cycles. The words follow one of four patterns:
// counter, LFSR, walking-one or constant.
//
// Ports
//   pcieClk_in     rising-edge clock for all logic
//   pcieRstN_in    asynchronous active-low reset
//   f2cReset_in    synchronous soft reset (DMA restart)
//   enable_in      run request
//   mode_in        pattern select: 0 counter, 1 LFSR, 2 walking-one, 3 constant
//   seed_in        first pattern word, captured on IDLE->RUN
//   burstLen_in    words per burst, 0 = unlimited
//   gap_in         idle cycles between bursts, 0 = no gap
//   f2cData_out    stream data
//   f2cValid_out   stream valid (registered)
//   f2cReady_in    stream ready
//   wordCount_out  handshakes since reset, modulo 2^32
//   busy_out       FSM not in IDLE
module f2c_pattern_src #(
  parameter int unsigned GAP_WIDTH = 8
) (
  input  logic                 pcieClk_in,
  input  logic                 pcieRstN_in,
  input  logic                 f2cReset_in,
  input  logic                 enable_in,
  input  logic [1:0]           mode_in,
  input  logic [63:0]          seed_in,
  input  logic [15:0]          burstLen_in,
  input  logic [GAP_WIDTH-1:0] gap_in,
  output logic [63:0]          f2cData_out,
  output logic                 f2cValid_out,
  input  logic                 f2cReady_in,
  output logic [31:0]          wordCount_out,
  output logic                 busy_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [63:0]          data, data_nxt, data_adv;
  logic                 valid, valid_nxt;
  logic [31:0]          word_count, word_count_nxt;
  logic [15:0]          burst_cnt, burst_cnt_nxt, burst_inc;
  logic [GAP_WIDTH-1:0] gap_cnt, gap_cnt_nxt;
  logic [1:0]           mode, mode_nxt;
  logic                 handshake;
  logic                 burst_last;

  assign handshake  = valid & f2cReady_in;
  assign burst_inc  = burst_cnt + 16'd1;
  assign burst_last = (burstLen_in != '0) && (burst_inc == burstLen_in);

  // Pattern advance for the latched mode.
  always_comb begin
    data_adv = data;
    case (mode)
      2'd0:    data_adv = data + 64'd1;
      2'd1:    data_adv = {data[62:0], data[63] ^ data[62] ^ data[60] ^ data[59]};
      2'd2:    data_adv = {data[62:0], data[63]};
      default: data_adv = data;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    data_nxt       = data;
    word_count_nxt = word_count;
    burst_cnt_nxt  = burst_cnt;
    gap_cnt_nxt    = gap_cnt;
    mode_nxt       = mode;

    if (f2cReset_in) begin
      state_nxt      = IDLE;
      data_nxt       = '0;
      word_count_nxt = '0;
      burst_cnt_nxt  = '0;
      gap_cnt_nxt    = '0;
      mode_nxt       = '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_in) begin
            state_nxt     = RUN;
            mode_nxt      = mode_in;
            burst_cnt_nxt = '0;
            // A walking-one pattern needs a set bit to walk.
            if ((mode_in == 2'd2) && (seed_in == '0))
              data_nxt = 64'h1;
            else
              data_nxt = seed_in;
          end
        end
        RUN: begin
          if (handshake) begin
            data_nxt       = data_adv;
            word_count_nxt = word_count + 32'd1;
            burst_cnt_nxt  = burst_last ? '0 : burst_inc;
            // A dropped enable wins over entering the gap.
            if (!enable_in) begin
              state_nxt = IDLE;
            end else if (burst_last && (gap_in != '0)) begin
              state_nxt   = GAP;
              gap_cnt_nxt = gap_in;
            end
          end
        end
        GAP: begin
          if (!enable_in) begin
            state_nxt   = IDLE;
            gap_cnt_nxt = '0;
          end else if (gap_cnt <= {{(GAP_WIDTH-1){1'b0}}, 1'b1}) begin
            state_nxt   = RUN;
            gap_cnt_nxt = '0;
          end else begin
            gap_cnt_nxt = gap_cnt - {{(GAP_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Valid is registered and tracks the next state.
    valid_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state      <= IDLE;
      data       <= '0;
      valid      <= 1'b0;
      word_count <= '0;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
      mode       <= '0;
    end else begin
      state      <= state_nxt;
      data       <= data_nxt;
      valid      <= valid_nxt;
      word_count <= word_count_nxt;
      burst_cnt  <= burst_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      mode       <= mode_nxt;
    end
  end

  assign f2cData_out   = data;
  assign f2cValid_out  = valid;
  assign wordCount_out = word_count;
  assign busy_out      = (state != IDLE);

endmodule

// File: tb/tb_f2c_pattern_src.sv
// Directed bench for f2c_pattern_src. Inputs change on the falling edge and
// outputs are sampled there too. The design samples on the rising edge.
module tb_f2c_pattern_src;

  logic        clk;
  logic        rst_n;
  logic        soft_rst;
  logic        enable;
  logic [1:0]  mode;
  logic [63:0] seed;
  logic [15:0] burst_len;
  logic [7:0]  gap;
  logic [63:0] data;
  logic        valid;
  logic        ready;
  logic [31:0] word_count;
  logic        busy;

  int unsigned vectors;
  int unsigned miscompares;

  f2c_pattern_src #(.GAP_WIDTH(8)) dut (
    .pcieClk_in    (clk),
    .pcieRstN_in   (rst_n),
    .f2cReset_in   (soft_rst),
    .enable_in     (enable),
    .mode_in       (mode),
    .seed_in       (seed),
    .burstLen_in   (burst_len),
    .gap_in        (gap),
    .f2cData_out   (data),
    .f2cValid_out  (valid),
    .f2cReady_in   (ready),
    .wordCount_out (word_count),
    .busy_out      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] d,
                         input logic [31:0] c, input logic b);
    chk({tag, ".valid"}, {63'd0, valid}, {63'd0, v});
    chk({tag, ".data"},  data, d);
    chk({tag, ".count"}, {32'd0, word_count}, {32'd0, c});
    chk({tag, ".busy"},  {63'd0, busy}, {63'd0, b});
  endtask

  logic        gap_valid [12];
  logic [63:0] gap_data  [12];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    soft_rst  = 1'b0;
    enable    = 1'b0;
    mode      = 2'd0;
    seed      = 64'd0;
    burst_len = 16'd0;
    gap       = 8'd0;
    ready     = 1'b1;

    #2;
    chk_out("reset", 1'b0, 64'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk_out("idle", 1'b0, 64'd0, 32'd0, 1'b0);

    // Counter mode, back-to-back.
    mode = 2'd0; seed = 64'd5; enable = 1'b1;
    step(); chk_out("cnt0", 1'b1, 64'd5, 32'd0, 1'b1);
    step(); chk_out("cnt1", 1'b1, 64'd6, 32'd1, 1'b1);
    step(); chk_out("cnt2", 1'b1, 64'd7, 32'd2, 1'b1);
    step(); chk_out("cnt3", 1'b1, 64'd8, 32'd3, 1'b1);
    step(); chk_out("cnt4", 1'b1, 64'd9, 32'd4, 1'b1);
    // Mode and seed changes while running are ignored.
    mode = 2'd3; seed = 64'd0;
    step(); chk_out("cnt_ignore", 1'b1, 64'd10, 32'd5, 1'b1);
    enable = 1'b0;
    step(); chk_out("cnt_stop", 1'b0, 64'd11, 32'd6, 1'b0);

    // Backpressure stall.
    mode = 2'd0; seed = 64'd0; enable = 1'b1; ready = 1'b0;
    step(); chk_out("stall1", 1'b1, 64'd0, 32'd6, 1'b1);
    step(); chk_out("stall2", 1'b1, 64'd0, 32'd6, 1'b1);
    step(); chk_out("stall3", 1'b1, 64'd0, 32'd6, 1'b1);
    step(); chk_out("stall4", 1'b1, 64'd0, 32'd6, 1'b1);
    ready = 1'b1;
    step(); chk_out("stall_go", 1'b1, 64'd1, 32'd7, 1'b1);

    // Enable drop mid-stall: valid held, one more handshake, then idle.
    ready = 1'b0; enable = 1'b0;
    step(); chk_out("drop_hold1", 1'b1, 64'd1, 32'd7, 1'b1);
    step(); chk_out("drop_hold2", 1'b1, 64'd1, 32'd7, 1'b1);
    ready = 1'b1;
    step(); chk_out("drop_last", 1'b0, 64'd2, 32'd8, 1'b0);
    step(); chk_out("drop_idle", 1'b0, 64'd2, 32'd8, 1'b0);

    // Burst of 4 with gap 3.
    gap_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    gap_data  = '{64'd100, 64'd101, 64'd102, 64'd103, 64'd104, 64'd104,
                  64'd104, 64'd104, 64'd105, 64'd106, 64'd107, 64'd108};
    mode = 2'd0; seed = 64'd100; burst_len = 16'd4; gap = 8'd3; enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("burst%0d.valid", i), {63'd0, valid}, {63'd0, gap_valid[i]});
      chk($sformatf("burst%0d.data", i), data, gap_data[i]);
    end
    chk("burst.count", {32'd0, word_count}, 64'd16);
    chk("burst.busy", {63'd0, busy}, 64'd1);
    // Enable low during the gap goes straight to idle.
    enable = 1'b0;
    step(); chk_out("gap_drop", 1'b0, 64'd108, 32'd16, 1'b0);

    // Burst end coinciding with enable low: idle wins over gap.
    seed = 64'd0; burst_len = 16'd2; gap = 8'd5; enable = 1'b1;
    step(); chk_out("prio0", 1'b1, 64'd0, 32'd16, 1'b1);
    step(); chk_out("prio1", 1'b1, 64'd1, 32'd17, 1'b1);
    enable = 1'b0;
    step(); chk_out("prio_idle", 1'b0, 64'd2, 32'd18, 1'b0);

    // LFSR from seed 1.
    burst_len = 16'd0; gap = 8'd0;
    mode = 2'd1; seed = 64'd1; enable = 1'b1;
    step(); chk("lfsr_a0", data, 64'h1);
    step(); chk("lfsr_a1", data, 64'h2);
    step(); chk("lfsr_a2", data, 64'h4);
    enable = 1'b0;
    step(); chk_out("lfsr_a_end", 1'b0, 64'h8, 32'd21, 1'b0);

    // LFSR feedback from the top bit.
    mode = 2'd1; seed = 64'h8000_0000_0000_0000; enable = 1'b1;
    step(); chk("lfsr_b0", data, 64'h8000_0000_0000_0000);
    enable = 1'b0;
    step(); chk_out("lfsr_b1", 1'b0, 64'h1, 32'd22, 1'b0);

    // Walking-one with a zero seed.
    mode = 2'd2; seed = 64'd0; enable = 1'b1;
    step(); chk("walk0", data, 64'h1);
    step(); chk("walk1", data, 64'h2);
    step(); chk("walk2", data, 64'h4);
    enable = 1'b0;
    step(); chk_out("walk_end", 1'b0, 64'h8, 32'd25, 1'b0);

    // Asynchronous reset mid-burst, between clock edges.
    mode = 2'd0; seed = 64'd50; burst_len = 16'd4; gap = 8'd2; enable = 1'b1;
    step(); chk("arst_pre0", data, 64'd50);
    step(); chk("arst_pre1", data, 64'd51);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 1'b0, 64'd0, 32'd0, 1'b0);
    enable = 1'b0;
    #1;
    rst_n = 1'b1;
    step(); chk_out("arst_quiet", 1'b0, 64'd0, 32'd0, 1'b0);

    // Soft reset mid-stall with valid high.
    enable = 1'b1;
    step(); chk("srst_pre0", data, 64'd50);
    step(); chk("srst_pre1", data, 64'd51);
    ready = 1'b0; soft_rst = 1'b1;
    step(); chk_out("srst", 1'b0, 64'd0, 32'd0, 1'b0);
    soft_rst = 1'b0; enable = 1'b0; ready = 1'b1;
    step(); chk_out("srst_quiet", 1'b0, 64'd0, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/f2c_pattern_src.md
F2C_PATTERN_SRC -- requirements
Module: f2c_pattern_src

Interface
REQ-001 The block SHALL have one parameter: GAP_WIDTH, default 8, width of the inter-burst gap count.
REQ-002 The block SHALL have one clock, pcieClk_in, and one reset, pcieRstN_in; reset is asynchronous and active-low.
REQ-003 Ports (name  direction  width  meaning):
- pcieClk_in  in  1  125MHz PCIe clock; all logic is clocked on its rising edge.
- pcieRstN_in  in  1  asynchronous active-low reset.
- f2cReset_in  in  1  synchronous soft reset from the TLP transceiver (DMA restart).
- enable_in  in  1  run request.
- mode_in  in  2  pattern select: 0 counter, 1 LFSR, 2 walking-one, 3 constant.
- seed_in  in  64  initial pattern word.
- burstLen_in  in  16  words per burst; 0 means unlimited.
- gap_in  in  GAP_WIDTH  idle cycles between bursts; 0 means no gap.
- f2cData_out  out  64  DMA stream data.
- f2cValid_out  out  1  data valid.
- f2cReady_in  in  1  downstream ready.
- wordCount_out  out  32  words accepted since last reset, wrapping modulo 2^32.
- busy_out  out  1  high when the FSM is not IDLE.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and GAP.
REQ-005 A handshake SHALL occur on any rising edge where f2cValid_out and f2cReady_in are both 1.
REQ-006 f2cValid_out SHALL be 1 only in RUN; it is a registered output.
REQ-007 While f2cValid_out=1 and f2cReady_in=0, f2cData_out SHALL hold stable.
REQ-008 In IDLE with enable_in=1 and f2cReset_in=0, the block SHALL do all of the following on one edge:
- enter RUN;
- latch mode_in into an internal mode register;
- load the pattern register with seed_in, except in mode 2 with seed_in=0, where it loads 64'h1;
- clear the burst counter.
The first f2cValid_out=1 SHALL appear in the cycle after enable_in is sampled high.
REQ-009 Changes to mode_in and seed_in outside the IDLE->RUN edge SHALL have no effect.
REQ-010 On each handshake, the pattern register SHALL advance according to the latched mode:
- counter: data+1, modulo 2^64;
- LFSR: {data[62:0], data[63]^data[62]^data[60]^data[59]};
- walking-one: rotate left by 1;
- constant: unchanged.
REQ-011 On each handshake, wordCount_out SHALL increment by 1, wrapping from 2^32-1 to 0.
REQ-012 Burst counting: with burstLen_in=N>0, the burst counter SHALL count handshakes.
- At the Nth handshake, the counter clears.
- If gap_in=G>0, the FSM enters GAP with the gap counter loaded with G.
- If gap_in=0, the FSM remains in RUN.
REQ-013 With burstLen_in=0, the FSM SHALL never enter GAP.
REQ-014 GAP SHALL last exactly G cycles with f2cValid_out=0, then return to RUN; the pattern register is retained across the gap.
REQ-015 When enable_in falls in RUN with f2cValid_out=1, the block SHALL NOT withdraw valid; it SHALL enter IDLE on the next handshake.
REQ-016 When enable_in=0 in GAP, the block SHALL enter IDLE on the next edge.
REQ-017 When a burst-end handshake and enable_in=0 coincide, IDLE SHALL take priority over GAP.
REQ-018 busy_out SHALL be 1 in RUN and GAP and 0 in IDLE.

Reset
REQ-019 When pcieRstN_in=0, all of the following SHALL hold immediately, independent of the clock:
- state = IDLE;
- f2cValid_out = 0;
- f2cData_out = 0;
- wordCount_out = 0;
- burst and gap counters = 0;
- mode register = 0.
REQ-020 f2cReset_in=1 SHALL produce the same values as REQ-019 on the next edge, in any state, including mid-stall with valid high; it overrides enable_in and handshakes in that cycle.
REQ-021 After either reset, no f2cValid_out=1 SHALL appear until enable_in is sampled high in IDLE.

Verification
REQ-022 Counter mode, back-to-back:
- stimulus: mode 0, seed 5, burstLen 0, ready=1, enable=1;
- response: data 5,6,7,8 on consecutive cycles, with wordCount_out reading 4 after the fourth handshake.
REQ-023 Backpressure stall:
- stimulus: mode 0, seed 0; ready low for 3 cycles after the first valid;
- response: data holds 0 for 4 cycles, then 1; wordCount_out does not advance during the stall.
REQ-024 Burst with gap:
- stimulus: burstLen 4, gap 3, ready=1;
- response: valid pattern 1111 000 1111; data is continuous across the gap.
REQ-025 LFSR and walking-one sequences:
- mode 1, seed 1 -> 0x1, 0x2, 0x4;
- mode 1, seed 64'h8000000000000000 -> next word 64'h1;
- mode 2, seed 0 -> 0x1, 0x2, 0x4.
REQ-026 Enable drop mid-stall:
- stimulus: enable falls while valid=1 and ready=0, then ready rises;
- response: exactly one more handshake occurs, then IDLE with busy_out=0.
REQ-027 Reset during operation:
- stimulus: pcieRstN_in pulsed low mid-burst with no clock edge;
- response: valid, data and count read 0 immediately.
- stimulus: f2cReset_in asserted for one cycle mid-burst;
- response: the same values on the next edge.
